// File: rtl/bloco_operativo_horner.sv
// Horner-rule polynomial evaluator: H <= H*X + coef, coefficients streamed highest order first.
// Define SATURATION_EN to clamp overflowing step values to 2^W-1 instead of wrapping.
module bloco_operativo_horner #(
  parameter int W    = 16,
  parameter int KW   = 8,
  parameter int GRAU = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inicio,
  input  logic [KW-1:0] K,
  input  logic [W-1:0]  coef,
  input  logic          coef_valido,
  output logic          coef_pronto,
  input  logic          cancela,
  output logic [W-1:0]  resultado,
  output logic          pronto,
  output logic          ocupado,
  output logic          overflow
);

  localparam int NW = (GRAU > 0) ? $clog2(GRAU + 1) : 1;
  localparam logic [NW-1:0] N_ULT = NW'(GRAU);

  typedef enum logic {OCIOSO, CARGA} estado_t;

  estado_t       estado;
  logic [W-1:0]  X, H, S;
  logic [NW-1:0] n;

  logic [2*W-1:0] prod;
  logic [2*W:0]   v;
  logic           stepOvf;
  logic [W-1:0]   stepVal;
  logic           hs;

  // Full-precision step so the overflow test sees every carried-out bit.
  always_comb begin
    prod    = H * X;
    v       = {1'b0, prod} + {{(W + 1){1'b0}}, coef};
    stepOvf = |v[2*W:W];
`ifdef SATURATION_EN
    stepVal = stepOvf ? {W{1'b1}} : v[W-1:0];
`else
    stepVal = v[W-1:0];
`endif
  end

  assign coef_pronto = (estado == CARGA);
  assign ocupado     = (estado == CARGA);
  assign hs          = coef_valido & coef_pronto;
  assign resultado   = S;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= OCIOSO;
      X        <= '0;
      H        <= '0;
      S        <= '0;
      n        <= '0;
      pronto   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            X        <= W'(K);
            H        <= '0;
            n        <= '0;
            overflow <= 1'b0;
            estado   <= CARGA;
          end
        end
        CARGA: begin
          // Abort wins over a coefficient arriving in the same cycle.
          if (cancela) begin
            overflow <= 1'b0;
            estado   <= OCIOSO;
          end else if (hs) begin
            overflow <= overflow | stepOvf;
            if (n == N_ULT) begin
              S      <= stepVal;
              pronto <= 1'b1;
              estado <= OCIOSO;
            end else begin
              H <= stepVal;
              n <= n + NW'(1);
            end
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_bloco_operativo_horner.sv
// Randomized self-checking bench for bloco_operativo_horner (GRAU=2 and GRAU=0 instances).
module tb_bloco_operativo_horner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        inicio, coef_valido, cancela;
  logic [7:0]  K;
  logic [15:0] coef;
  logic        coef_pronto, pronto, ocupado, overflow;
  logic [15:0] resultado;

  logic        inicio1, coef_valido1, cancela1;
  logic [7:0]  K1;
  logic [15:0] coef1;
  logic        coef_pronto1, pronto1, ocupado1, overflow1;
  logic [15:0] resultado1;

  int errCnt = 0;
  int chkCnt = 0;

  bloco_operativo_horner #(.W(16), .KW(8), .GRAU(2)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .K(K), .coef(coef),
    .coef_valido(coef_valido), .coef_pronto(coef_pronto), .cancela(cancela),
    .resultado(resultado), .pronto(pronto), .ocupado(ocupado), .overflow(overflow)
  );

  bloco_operativo_horner #(.W(16), .KW(8), .GRAU(0)) dut0 (
    .clk(clk), .rst(rst), .inicio(inicio1), .K(K1), .coef(coef1),
    .coef_valido(coef_valido1), .coef_pronto(coef_pronto1), .cancela(cancela1),
    .resultado(resultado1), .pronto(pronto1), .ocupado(ocupado1), .overflow(overflow1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain polynomial evaluation, one Horner step per coefficient.
  function automatic void model(input int unsigned k, input int unsigned cs[3], input int nc,
                                output int unsigned res, output bit ovf);
    longint h = 0;
    longint v;
    ovf = 0;
    for (int i = 0; i < nc; i++) begin
      v = h * k + cs[i];
      if (v >= 65536) begin
        ovf = 1;
`ifdef SATURATION_EN
        v = 65535;
`else
        v = v % 65536;
`endif
      end
      h = v;
    end
    res = int'(h);
  endfunction

  task automatic runEval(input string tag, input int unsigned k, input int unsigned c0,
                         input int unsigned c1, input int unsigned c2, input int gapMax);
    int unsigned cs[3];
    int unsigned expRes;
    bit expOvf;
    int gap;
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    model(k, cs, 3, expRes, expOvf);
    inicio = 1'b1; K = k[7:0];
    step();
    inicio = 1'b0;
    chk({tag, ".coefPronto"}, coef_pronto, 1);
    for (int i = 0; i < 3; i++) begin
      coef = cs[i][15:0]; coef_valido = 1'b1;
      step();
      coef_valido = 1'b0;
      if (i < 2) begin
        chk({tag, ".noPronto"}, pronto, 0);
        gap = (gapMax > 0) ? $urandom_range(gapMax, 0) : 0;
        if (tag == "backp") gap = 2;
        repeat (gap) begin
          step();
          chk({tag, ".ocupado"}, ocupado, 1);
        end
      end
    end
    chk({tag, ".pronto"}, pronto, 1);
    chk({tag, ".resultado"}, resultado, expRes);
    chk({tag, ".overflow"}, overflow, expOvf);
    chk({tag, ".idle"}, ocupado, 0);
    step();
    chk({tag, ".prontoPulse"}, pronto, 0);
    chk({tag, ".hold"}, resultado, expRes);
  endtask

  initial begin
    int unsigned kr, a, b, c;
    rst = 1'b1; inicio = 0; coef_valido = 0; cancela = 0; K = 0; coef = 0;
    inicio1 = 0; coef_valido1 = 0; cancela1 = 0; K1 = 0; coef1 = 0;
    step(); step();
    chk("rst.resultado", resultado, 0);
    chk("rst.pronto", pronto, 0);
    chk("rst.coefPronto", coef_pronto, 0);
    chk("rst.ocupado", ocupado, 0);
    chk("rst.overflow", overflow, 0);
    rst = 1'b0;
    step();

    runEval("basic", 3, 2, 5, 7, 0);
    runEval("ovf", 255, 1000, 0, 0, 0);
    runEval("backp", 3, 2, 5, 7, 2);

    // Cancel after completion of a 40-result evaluation; cancel beats a same-cycle coefficient.
    runEval("pre", 3, 2, 5, 7, 0);
    inicio = 1; K = 2; step(); inicio = 0;
    coef = 1; coef_valido = 1; step();
    coef = 1; step();
    cancela = 1; step();
    cancela = 0; coef_valido = 0;
    chk("cancel.ocupado", ocupado, 0);
    chk("cancel.pronto", pronto, 0);
    chk("cancel.resultado", resultado, 40);
    step();
    chk("cancel.pronto2", pronto, 0);
    chk("cancel.resultado2", resultado, 40);

    // Cancel clears an overflow raised mid-evaluation.
    inicio = 1; K = 255; step(); inicio = 0;
    coef = 1000; coef_valido = 1; step();
    coef = 0; step();
    coef_valido = 0;
    chk("cancelOvf.before", overflow, 1);
    cancela = 1; coef_valido = 1; step();
    cancela = 0; coef_valido = 0;
    chk("cancelOvf.cleared", overflow, 0);
    chk("cancelOvf.resultado", resultado, 40);
    // inicio in OCIOSO with cancela ignored as start? cancela has no effect in OCIOSO.
    cancela = 1; step(); cancela = 0;
    chk("cancelIdle.ocupado", ocupado, 0);

    // Reset mid-load: asynchronous, visible without a clock edge.
    inicio = 1; K = 3; step(); inicio = 0;
    coef = 2; coef_valido = 1; step(); coef_valido = 0;
    rst = 1; #1;
    chk("rstMid.resultado", resultado, 0);
    chk("rstMid.ocupado", ocupado, 0);
    chk("rstMid.coefPronto", coef_pronto, 0);
    chk("rstMid.pronto", pronto, 0);
    chk("rstMid.overflow", overflow, 0);
    step(); rst = 0; step();
    runEval("afterRst", 1, 1, 1, 1, 0);

    for (int it = 0; it < 20; it++) begin
      kr = $urandom_range(255, 0);
      if ($urandom_range(1, 0) == 1) begin
        a = $urandom_range(65535, 0); b = $urandom_range(65535, 0); c = $urandom_range(65535, 0);
      end else begin
        a = $urandom_range(40, 0); b = $urandom_range(300, 0); c = $urandom_range(9000, 0);
      end
      runEval("rand", kr, a, b, c, 2);
    end

    // GRAU=0 instance: single coefficient goes straight to S; back-to-back start in pronto cycle.
    inicio1 = 1; K1 = 9; step(); inicio1 = 0;
    chk("g0.coefPronto", coef_pronto1, 1);
    coef1 = 1234; coef_valido1 = 1; step(); coef_valido1 = 0;
    chk("g0.pronto", pronto1, 1);
    chk("g0.resultado", resultado1, 1234);
    chk("g0.overflow", overflow1, 0);
    inicio1 = 1; K1 = 5; step(); inicio1 = 0;
    chk("g0.b2bAccepted", coef_pronto1, 1);
    chk("g0.b2bPronto", pronto1, 0);
    coef1 = 77; coef_valido1 = 1; step(); coef_valido1 = 0;
    chk("g0.b2bResultado", resultado1, 77);
    chk("g0.b2bPronto2", pronto1, 1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/bloco_operativo_horner.md
# bloco_operativo_horner

Parametrised successor to the fixed three-operand datapath. It evaluates a polynomial of configurable degree in an unsigned point K using Horner's rule (H ← H·X + coef). Coefficients stream in over a valid/ready handshake, highest order first. A small internal controller sequences the X/H/S register set, so an external control block only issues `inicio` and waits for `pronto`.

## Interface
- `W`, 16: coefficient, accumulator and result width.
- `KW`, 8: width of point K; must satisfy KW ≤ W.
- `GRAU`, 2: polynomial degree; GRAU+1 coefficients per evaluation; GRAU ≥ 0.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `inicio  in  1`: start request, sampled in OCIOSO only.
- `K  in  KW`: evaluation point, captured into X on an accepted `inicio`.
- `coef  in  W`: coefficient data.
- `coef_valido  in  1`: `coef` valid.
- `coef_pronto  out  1`: block accepts a coefficient.
- `cancela  in  1`: abort the current evaluation.
- `resultado  out  W`: register S, the last completed result.
- `pronto  out  1`: one-cycle completion pulse.
- `ocupado  out  1`: high while in CARGA.
- `overflow  out  1`: sticky overflow flag for the current or last evaluation.

## Operation
- Registers:
  - X (W bits) holds K zero-extended.
  - H (W bits) is the Horner accumulator.
  - S (W bits) drives `resultado`.
  - Coefficient counter `n` counts 0..GRAU.
- FSM states are OCIOSO and CARGA.
- OCIOSO:
  - `coef_pronto`=0, `ocupado`=0.
  - On `inicio`=1: X←K, H←0, n←0, overflow←0, go to CARGA.
  - S keeps its previous value.
- CARGA:
  - `coef_pronto`=1, `ocupado`=1.
  - Handshake is `coef_valido & coef_pronto`. On each handshake the step value is v = H·X + coef, computed at full 2W+1-bit precision.
  - If v ≥ 2^W, overflow←1.
  - Stored step value: v mod 2^W, or a clamp to 2^W−1 (see Configuration).
  - If n < GRAU: H←step value, n←n+1.
  - If n = GRAU: S←step value, `pronto`←1, go to OCIOSO.
- `cancela`=1 in CARGA has priority over a same-cycle handshake:
  - go to OCIOSO.
  - S is unchanged; no `pronto`; overflow is cleared.
- `cancela` in OCIOSO has no effect.
- `inicio` in CARGA is ignored.
- `inicio` is accepted in the OCIOSO cycle in which `pronto`=1.
- GRAU=0: the single coefficient goes directly to S.
- First step: H=0, so H←coef exactly, with no overflow possible.

## Timing
- Reset values: `resultado`=0, `pronto`=0, `coef_pronto`=0, `ocupado`=0, `overflow`=0; X=H=0, n=0, state OCIOSO.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Accepted `inicio` at edge t: `coef_pronto`=1 from t+1.
- Latency: `resultado` updates and `pronto`=1 one cycle after the final handshake. Minimum evaluation is GRAU+2 cycles from `inicio`.
- `pronto` is high for exactly one cycle.
- `overflow` is updated on the same edge as S or H. It stays valid until the next accepted `inicio` or `cancela`.
- Gaps in `coef_valido` stall the FSM without state change.
- `rst` mid-evaluation: immediate return to reset values; the partial result is discarded.

## Configuration
- `SATURATION_EN` defined:
  - A step value ≥ 2^W is stored as 2^W−1.
  - Later steps start from the clamped value, and any result ≥ 2^W after every step is clamped again.
  - `overflow` is still set.
- `SATURATION_EN` undefined: modulo-2^W wrap; `overflow` is still set.

## Test plan
- All scenarios use W=16, KW=8, GRAU=2 unless stated otherwise.
- Basic evaluation: K=3, coefs 2,5,7 back-to-back. Required: `resultado`=40, `pronto` one cycle after the third handshake, `overflow`=0.
- Overflow: K=255, coefs 1000,0,0.
  - Without macro: `resultado`=13288, `overflow`=1.
  - With `SATURATION_EN`: `resultado`=65535, `overflow`=1.
- Backpressure: K=3, coefs 2,5,7 with `coef_valido` low 2 cycles between each. Required: `resultado`=40, and `ocupado` stays high throughout.
- Cancel: evaluate K=3 with coefs 2,5,7 to completion, then `inicio` with K=2, coefs 1,1, then `cancela`. Required: `resultado` stays 40, no `pronto`, `ocupado`=0 next cycle.
- Reset mid-load: assert `rst` after the first coefficient. Required: all outputs 0 immediately. A new K=1 evaluation with coefs 1,1,1 gives `resultado`=3.
- GRAU=0 build: K=9, coef 1234. Required: `resultado`=1234, `pronto` one cycle after the handshake. A back-to-back `inicio` in the `pronto` cycle is accepted.
